tcdm_burst_master: RTL and testbench



---
 rtl/tcdm_burst_pkg.sv | 24 ++
 rtl/tcdm_burst_master_if.sv | 24 ++
 rtl/tcdm_burst_rsp_fifo.sv | 47 ++++
 rtl/tcdm_burst_master.sv | 140 ++++++++++++++
 tb/tb_tcdm_burst_master.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tcdm_burst_pkg.sv
// Shared types and constants for the TCDM burst master.
package tcdm_burst_pkg;

  localparam int WORD_BYTES = 4;
  // Widest address/length the live command register can carry; the top truncates to its port widths.
  localparam int CMD_ADDR_W = 64;
  localparam int CMD_LEN_W  = 32;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    DRAIN,
    DONE
  } burst_state_e;

  typedef struct packed {
    logic                  write;
    logic [CMD_ADDR_W-1:0] addr;
    logic [CMD_LEN_W-1:0]  len;
    logic [3:0]            be;
  } burst_cmd_t;

endpackage

// File: rtl/tcdm_burst_master_if.sv
// TCDM bank port: single-word request/grant with a fixed 1-cycle read response.
interface tcdm_burst_master_if #(
  parameter int ADDR_WIDTH = 32
) ();

  logic                  req;
  logic                  gnt;
  logic                  wen;
  logic [ADDR_WIDTH-1:0] add;
  logic [31:0]           wdata;
  logic [3:0]            be;
  logic [31:0]           r_data;

  modport master (
    output req, wen, add, wdata, be,
    input  gnt, r_data
  );

  modport slave (
    input  req, wen, add, wdata, be,
    output gnt, r_data
  );

endinterface

// File: rtl/tcdm_burst_rsp_fifo.sv
// Read-response FIFO; its occupancy feeds the master's request credit.
module tcdm_burst_rsp_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;

  always_ff @(posedge clk_i) begin
    if (push_i) mem[wr_ptr] <= data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_i) wr_ptr <= wr_ptr + 1'b1;
      if (pop_i)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign empty_o = (count == '0);
  assign count_o = count;
  // Masked so the data output reads as zero whenever nothing is held.
  assign data_o  = empty_o ? '0 : mem[rd_ptr];

endmodule

// File: rtl/tcdm_burst_master.sv
// Burst-to-single-word TCDM initiator with buffered read responses.
// Optional perf counters are built when TCDM_BURST_MASTER_PERF_EN is defined.
module tcdm_burst_master
  import tcdm_burst_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_write_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [LEN_WIDTH-1:0]  cmd_len_i,
  input  logic [3:0]            cmd_be_i,
  input  logic [31:0]           wdata_i,
  input  logic                  wvalid_i,
  output logic                  wready_o,
  output logic [31:0]           rdata_o,
  output logic                  rvalid_o,
  input  logic                  rready_i,
  output logic                  busy_o,
  output logic                  done_o,
  tcdm_burst_master_if.master   tcdm
`ifdef TCDM_BURST_MASTER_PERF_EN
  ,
  output logic [31:0]           perf_stall_cycles_o,
  output logic [31:0]           perf_beats_o
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  burst_state_e     state_q, state_d;
  burst_cmd_t       cmd_q;
  logic             inflight_q;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W-1:0] credit;
  logic             fifo_empty;
  logic             fifo_pop;
  logic             req_c;
  logic             beat;

  // Slots not yet spoken for: a granted read owns a slot until its data lands.
  assign credit   = CNT_W'(FIFO_DEPTH) - fifo_count - CNT_W'(inflight_q);
  assign req_c    = ((state_q == WRITE) && wvalid_i) || ((state_q == READ) && (credit != '0));
  assign beat     = req_c & tcdm.gnt;
  assign fifo_pop = ~fifo_empty & rready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cmd_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= beat & ~cmd_q.write;
      if ((state_q == IDLE) && cmd_valid_i) begin
        cmd_q.write <= cmd_write_i;
        cmd_q.addr  <= CMD_ADDR_W'(cmd_addr_i) & ~(CMD_ADDR_W'(WORD_BYTES - 1));
        cmd_q.len   <= CMD_LEN_W'(cmd_len_i);
        cmd_q.be    <= cmd_be_i;
      end else if (beat) begin
        cmd_q.addr <= cmd_q.addr + CMD_ADDR_W'(WORD_BYTES);
        cmd_q.len  <= cmd_q.len - 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cmd_ready_o = 1'b0;
    wready_o    = 1'b0;
    tcdm.req    = req_c;
    tcdm.wen    = 1'b1;
    tcdm.wdata  = '0;
    unique case (state_q)
      IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) begin
          if (cmd_len_i == '0)  state_d = DONE;
          else if (cmd_write_i) state_d = WRITE;
          else                  state_d = READ;
        end
      end
      WRITE: begin
        tcdm.wen   = 1'b0;
        tcdm.wdata = wdata_i;
        wready_o   = tcdm.gnt;
        if (beat && (cmd_q.len == CMD_LEN_W'(1))) state_d = DONE;
      end
      READ: begin
        if (beat && (cmd_q.len == CMD_LEN_W'(1))) state_d = DRAIN;
      end
      DRAIN: begin
        if (!inflight_q && fifo_empty) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign tcdm.add = cmd_q.addr[ADDR_WIDTH-1:0];
  assign tcdm.be  = cmd_q.be;
  assign busy_o   = (state_q != IDLE);
  assign done_o   = (state_q == DONE);
  assign rvalid_o = ~fifo_empty;

  tcdm_burst_rsp_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_rsp_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (inflight_q),
    .data_i  (tcdm.r_data),
    .pop_i   (fifo_pop),
    .data_o  (rdata_o),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

`ifdef TCDM_BURST_MASTER_PERF_EN
  // Saturating counters that accumulate across bursts until reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_stall_cycles_o <= '0;
      perf_beats_o        <= '0;
    end else begin
      if (req_c && !tcdm.gnt && !(&perf_stall_cycles_o))
        perf_stall_cycles_o <= perf_stall_cycles_o + 1'b1;
      if (beat && !(&perf_beats_o))
        perf_beats_o <= perf_beats_o + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_tcdm_burst_master.sv
// Directed bench for tcdm_burst_master with a request/read-data scoreboard and a TCDM bank model.
module tb_tcdm_burst_master;

  typedef struct {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] data;
    logic [3:0]  be;
  } exp_req_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_write;
  logic [31:0] cmd_addr;
  logic [15:0] cmd_len;
  logic [3:0]  cmd_be;
  logic [31:0] wdata;
  logic        wvalid, rready;
  logic        cmd_ready_o, wready_o, rvalid_o, busy_o, done_o;
  logic [31:0] rdata_o;
  logic [31:0] rsp_data;
`ifdef TCDM_BURST_MASTER_PERF_EN
  logic [31:0] perf_stall, perf_beats;
`endif

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int gnt_mode = 0;
  int grant_cnt = 0, req_cycles = 0, rd_pop_cnt = 0, done_cnt = 0;
  int last_gnt_cyc = 0, last_pop_cyc = 0, done_cyc = 0, accept_cyc = 0;
  logic prev_done = 1'b0;
  logic chk_wready = 1'b0;
  exp_req_t exp_req_q[$];
  logic [31:0] exp_rd_q[$];
  exp_req_t head;

  tcdm_burst_master_if #(.ADDR_WIDTH(32)) tcdm_bus ();

  tcdm_burst_master #(
    .ADDR_WIDTH (32),
    .LEN_WIDTH  (16),
    .FIFO_DEPTH (4)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready_o),
    .cmd_write_i (cmd_write),
    .cmd_addr_i  (cmd_addr),
    .cmd_len_i   (cmd_len),
    .cmd_be_i    (cmd_be),
    .wdata_i     (wdata),
    .wvalid_i    (wvalid),
    .wready_o    (wready_o),
    .rdata_o     (rdata_o),
    .rvalid_o    (rvalid_o),
    .rready_i    (rready),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .tcdm        (tcdm_bus)
`ifdef TCDM_BURST_MASTER_PERF_EN
    ,
    .perf_stall_cycles_o (perf_stall),
    .perf_beats_o        (perf_beats)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return a ^ 32'h5EED_0000;
  endfunction

  // Bank model: grant pattern per gnt_mode, read data one cycle after a granted read.
  always @(posedge clk) begin
    rsp_data <= (tcdm_bus.req && tcdm_bus.gnt && tcdm_bus.wen) ? memWord(tcdm_bus.add) : 32'hDEAD_BEEF;
    #1;
    case (gnt_mode)
      0:       tcdm_bus.gnt = 1'b1;
      1:       tcdm_bus.gnt = ((cyc % 3) == 0);
      default: tcdm_bus.gnt = 1'b0;
    endcase
  end
  assign tcdm_bus.r_data = rsp_data;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pushWrite(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    exp_req_t e;
    e.addr = a; e.wen = 1'b0; e.data = d; e.be = be;
    exp_req_q.push_back(e);
  endtask

  task automatic pushRead(input logic [31:0] a, input logic [3:0] be);
    exp_req_t e;
    e.addr = a; e.wen = 1'b1; e.data = '0; e.be = be;
    exp_req_q.push_back(e);
    exp_rd_q.push_back(memWord(a));
  endtask

  // Scoreboard monitor: every requesting cycle is checked against the head entry, popped on grant.
  always @(negedge clk) begin
    if (!rst) begin
      if (tcdm_bus.req) begin
        req_cycles++;
        if (exp_req_q.size() == 0) begin
          checkOutput("req_unexpected_gnt", 32'(tcdm_bus.gnt), 32'd0);
        end else begin
          head = exp_req_q[0];
          checkOutput("req_addr", tcdm_bus.add, head.addr);
          checkOutput("req_wen", 32'(tcdm_bus.wen), 32'(head.wen));
          checkOutput("req_be", 32'(tcdm_bus.be), 32'(head.be));
          if (!head.wen) checkOutput("req_wdata", tcdm_bus.wdata, head.data);
          if (tcdm_bus.gnt) void'(exp_req_q.pop_front());
        end
        if (tcdm_bus.gnt) begin
          grant_cnt++;
          last_gnt_cyc = cyc;
        end
      end
      if (rvalid_o && rready) begin
        if (exp_rd_q.size() == 0) checkOutput("rdata_unexpected", 32'(rvalid_o), 32'd0);
        else checkOutput("rdata", rdata_o, exp_rd_q.pop_front());
        rd_pop_cnt++;
        last_pop_cyc = cyc;
      end
      if (chk_wready && busy_o && !done_o)
        checkOutput("wready_vs_gnt", 32'(wready_o), 32'(tcdm_bus.gnt));
      if (done_o) begin
        checkOutput("done_width", 32'(prev_done), 32'd0);
        done_cnt++;
        done_cyc = cyc;
      end
      prev_done = done_o;
    end
  end

  task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [15:0] len,
                               input logic [3:0] be);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_len = len; cmd_be = be;
    @(negedge clk);
    checkOutput("cmd_ready", 32'(cmd_ready_o), 32'd1);
    @(posedge clk); #1;
    accept_cyc = cyc - 1;
    cmd_valid = 1'b0;
  endtask

  task automatic sendWrites(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      logic ok;
      int   t;
      wvalid = 1'b1; wdata = base + 32'(i); ok = 1'b0; t = 0;
      while (!ok && t < 64) begin
        @(negedge clk);
        ok = wready_o;
        @(posedge clk); #1;
        t++;
      end
      if (!ok) checkOutput("wbeat_timeout", 32'(ok), 32'd1);
    end
    wvalid = 1'b0;
  endtask

  task automatic waitDone(input int budget);
    int start;
    int t;
    start = done_cnt; t = 0;
    while (done_cnt == start && t < budget) begin
      @(negedge clk); #1;
      t++;
    end
    checkOutput("done_seen", 32'(done_cnt - start), 32'd1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int base, base_req, base_pop, t;
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_be = '0;
    wdata = '0; wvalid = 1'b0; rready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_busy", 32'(busy_o), 32'd0);
    checkOutput("rst_done", 32'(done_o), 32'd0);
    checkOutput("rst_req", 32'(tcdm_bus.req), 32'd0);
    checkOutput("rst_wen", 32'(tcdm_bus.wen), 32'd1);
    checkOutput("rst_add", tcdm_bus.add, 32'd0);
    checkOutput("rst_rvalid", 32'(rvalid_o), 32'd0);
    checkOutput("rst_wready", 32'(wready_o), 32'd0);
    checkOutput("rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    $display("[TB] write burst 0x100 len 4, gnt always");
    gnt_mode = 0; base = grant_cnt; base_req = req_cycles;
    for (int i = 0; i < 4; i++) pushWrite(32'h100 + 32'(4 * i), 32'hA0 + 32'(i), 4'hF);
    applyStimulus(1'b1, 32'h100, 16'd4, 4'hF);
    sendWrites(4, 32'hA0);
    waitDone(20);
    checkOutput("wr_grants", 32'(grant_cnt - base), 32'd4);
    checkOutput("wr_req_cycles", 32'(req_cycles - base_req), 32'd4);
    checkOutput("wr_done_latency", 32'(done_cyc - last_gnt_cyc), 32'd1);
    checkOutput("wr_queue_empty", 32'(exp_req_q.size()), 32'd0);

    $display("[TB] read burst 0x200 len 8 with stalled consumer");
    base = grant_cnt; base_pop = rd_pop_cnt;
    for (int i = 0; i < 8; i++) pushRead(32'h200 + 32'(4 * i), 4'hF);
    applyStimulus(1'b0, 32'h200, 16'd8, 4'hF);
    repeat (10) @(negedge clk);
    #1;
    checkOutput("rd_credit_grants", 32'(grant_cnt - base), 32'd4);
    checkOutput("rd_credit_req_low", 32'(tcdm_bus.req), 32'd0);
    checkOutput("rd_rvalid", 32'(rvalid_o), 32'd1);
    @(posedge clk); #1;
    rready = 1'b1;
    waitDone(60);
    checkOutput("rd_pops", 32'(rd_pop_cnt - base_pop), 32'd8);
    checkOutput("rd_done_after_pop", 32'(done_cyc > last_pop_cyc), 32'd1);
    checkOutput("rd_queue_empty", 32'(exp_rd_q.size()), 32'd0);
    rready = 1'b0;

    $display("[TB] write burst with gnt pattern 1,0,0");
    gnt_mode = 1; base = grant_cnt;
    for (int i = 0; i < 4; i++) pushWrite(32'h400 + 32'(4 * i), 32'hB0 + 32'(i), 4'h5);
    chk_wready = 1'b1;
    applyStimulus(1'b1, 32'h400, 16'd4, 4'h5);
    sendWrites(4, 32'hB0);
    waitDone(20);
    chk_wready = 1'b0;
    checkOutput("stall_grants", 32'(grant_cnt - base), 32'd4);
    checkOutput("stall_queue_empty", 32'(exp_req_q.size()), 32'd0);
    gnt_mode = 0;

    $display("[TB] zero-length command");
    base_req = req_cycles;
    applyStimulus(1'b0, 32'h600, 16'd0, 4'hF);
    waitDone(4);
    checkOutput("len0_no_req", 32'(req_cycles - base_req), 32'd0);
    checkOutput("len0_done_latency", 32'((done_cyc - accept_cyc) >= 1 && (done_cyc - accept_cyc) <= 2), 32'd1);

    $display("[TB] read with address wrap");
    rready = 1'b1;
    pushRead(32'hFFFF_FFF8, 4'h3);
    pushRead(32'hFFFF_FFFC, 4'h3);
    pushRead(32'h0000_0000, 4'h3);
    pushRead(32'h0000_0004, 4'h3);
    applyStimulus(1'b0, 32'hFFFF_FFF8, 16'd4, 4'h3);
    waitDone(30);
    checkOutput("wrap_req_empty", 32'(exp_req_q.size()), 32'd0);
    checkOutput("wrap_rd_empty", 32'(exp_rd_q.size()), 32'd0);
    rready = 1'b0;

    $display("[TB] reset in the middle of a read burst");
    base = grant_cnt;
    for (int i = 0; i < 8; i++) pushRead(32'h300 + 32'(4 * i), 4'hF);
    applyStimulus(1'b0, 32'h300, 16'd8, 4'hF);
    t = 0;
    while ((grant_cnt - base) < 1 && t < 20) begin
      @(posedge clk); #2;
      t++;
    end
    checkOutput("rst_setup_grant", 32'((grant_cnt - base) >= 1), 32'd1);
    gnt_mode = 2;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    exp_req_q.delete();
    exp_rd_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midrst_busy", 32'(busy_o), 32'd0);
    checkOutput("midrst_rvalid", 32'(rvalid_o), 32'd0);
    checkOutput("midrst_req", 32'(tcdm_bus.req), 32'd0);
    checkOutput("midrst_cmd_ready", 32'(cmd_ready_o), 32'd1);
    gnt_mode = 0;

    $display("[TB] read after reset returns only fresh data");
    rready = 1'b1; base_pop = rd_pop_cnt;
    pushRead(32'h500, 4'hF);
    pushRead(32'h504, 4'hF);
    applyStimulus(1'b0, 32'h500, 16'd2, 4'hF);
    waitDone(30);
    checkOutput("post_rst_pops", 32'(rd_pop_cnt - base_pop), 32'd2);
    checkOutput("post_rst_rd_empty", 32'(exp_rd_q.size()), 32'd0);
    rready = 1'b0;

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
